// File: rtl/lpm_pkg.sv
// Shared types for the recirculating longest-prefix-match engine.
// The struct payloads use the package widths; the engine's META_W/KEY_W must match them.
package lpm_pkg;

  localparam int PASS_W     = 8;
  localparam int LPM_META_W = 32;
  localparam int LPM_KEY_W  = 32;

  typedef logic [PASS_W-1:0] pass_t;

  typedef struct packed {
    logic [LPM_META_W-1:0] meth;
    logic [LPM_KEY_W-1:0]  key;
  } lpm_req_t;

  typedef struct packed {
    logic [LPM_META_W-1:0] meth;
    pass_t                 pass;
  } lpm_flight_t;

  typedef struct packed {
    logic [LPM_META_W-1:0] meth;
    logic [LPM_KEY_W-1:0]  v;
  } lpm_res_t;

  // Saturating increment so a pass count can never wrap back to a small value.
  function automatic pass_t pass_inc(input pass_t p);
    return (p == '1) ? p : p + PASS_W'(1);
  endfunction

endpackage

// File: rtl/lpm_fifo.sv
// Small circular-buffer FIFO; an enqueue into a full FIFO is accepted when a dequeue
// happens in the same cycle.
module lpm_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enq,
  input  logic [WIDTH-1:0] enq_data,
  input  logic             deq,
  output logic [WIDTH-1:0] first,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] store [2**PTR_W];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             do_enq;
  logic             do_deq;

  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  assign do_deq = deq & ~empty;
  assign do_enq = enq & (~full | do_deq);
  assign first  = store[head];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_enq) tail <= (tail == LAST) ? '0 : tail + PTR_W'(1);
      if (do_deq) head <= (head == LAST) ? '0 : head + PTR_W'(1);
      if (do_enq & ~do_deq)      count <= count + CNT_W'(1);
      else if (do_deq & ~do_enq) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_enq) store[tail] <= enq_data;
  end

endmodule

// File: rtl/lpm_recirc_engine.sv
// Longest-prefix-match engine: lookups recirculate through one trie memory port until hit or MAX_PASSES.
// Optional statistics counters are compiled in with `define LPM_STATS_EN.
module lpm_recirc_engine
  import lpm_pkg::*;
#(
  parameter int META_W     = LPM_META_W,
  parameter int KEY_W      = LPM_KEY_W,
  parameter int ADDR_W     = 16,
  parameter int IN_DEPTH   = 2,
  parameter int INFLIGHT   = 4,
  parameter int OUT_DEPTH  = 2,
  parameter int MAX_PASSES = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              say__ENA,
  input  logic [META_W-1:0] say_meth,
  input  logic [KEY_W-1:0]  say_v,
  output logic              say__RDY,
  output logic              heard__ENA,
  output logic [META_W-1:0] heard_meth,
  output logic [KEY_W-1:0]  heard_v,
  input  logic              heard__RDY,
  output logic              mem_req__ENA,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req__RDY,
  input  logic              mem_resp__ENA,
  input  logic [ADDR_W-1:0] mem_resp_next,
  input  logic              mem_resp_hit,
  output logic              mem_resp__RDY
`ifdef LPM_STATS_EN
  ,
  output logic [31:0]       stat_req,
  output logic [31:0]       stat_recirc,
  output logic [31:0]       stat_forced
`endif
);

  lpm_req_t    in_data, in_first;
  lpm_flight_t fl_data, fl_first;
  lpm_res_t    out_data, out_first;
  logic        in_full, in_empty, fl_full, fl_empty, out_full, out_empty;
  logic        ready_q, say_fire, exit_sel, resp_fire, do_exit, do_recirc, do_enter;
  logic [KEY_W-ADDR_W-1:0] unused_key_hi;

  // Holds say__RDY low through reset even though the empty input queue is "not full".
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) ready_q <= 1'b0;
    else     ready_q <= 1'b1;
  end

  assign say__RDY  = ready_q & ~in_full;
  assign say_fire  = say__ENA & say__RDY;
  assign in_data   = {say_meth, say_v};

  assign exit_sel      = mem_resp_hit | (fl_first.pass == PASS_W'(MAX_PASSES));
  assign mem_resp__RDY = ~fl_empty & (exit_sel ? ~out_full : mem_req__RDY);
  assign resp_fire     = mem_resp__ENA & mem_resp__RDY;
  assign do_exit       = resp_fire & exit_sel;
  assign do_recirc     = resp_fire & ~exit_sel;
  // A recirculating lookup owns the memory port first so it always makes progress.
  assign do_enter      = ~in_empty & ~fl_full & mem_req__RDY & ~do_recirc;

  assign mem_req__ENA  = do_recirc | do_enter;
  assign mem_req_addr  = do_recirc ? mem_resp_next : in_first.key[ADDR_W-1:0];
  assign unused_key_hi = in_first.key[KEY_W-1:ADDR_W];

  always_comb begin
    fl_data = '0;
    if (do_recirc) begin
      fl_data.meth = fl_first.meth;
      fl_data.pass = pass_inc(fl_first.pass);
    end else begin
      fl_data.meth = in_first.meth;
      fl_data.pass = PASS_W'(1);
    end
  end

  assign out_data   = {fl_first.meth, {(KEY_W-ADDR_W){1'b0}}, mem_resp_next};
  assign heard__ENA = ~out_empty & heard__RDY;
  assign heard_meth = out_first.meth;
  assign heard_v    = out_first.v;

  lpm_fifo #(.WIDTH($bits(lpm_req_t)), .DEPTH(IN_DEPTH)) u_in_q (
    .clk(CLK), .rst(RST), .enq(say_fire), .enq_data(in_data), .deq(do_enter),
    .first(in_first), .full(in_full), .empty(in_empty)
  );

  lpm_fifo #(.WIDTH($bits(lpm_flight_t)), .DEPTH(INFLIGHT)) u_flight_q (
    .clk(CLK), .rst(RST), .enq(mem_req__ENA), .enq_data(fl_data), .deq(resp_fire),
    .first(fl_first), .full(fl_full), .empty(fl_empty)
  );

  lpm_fifo #(.WIDTH($bits(lpm_res_t)), .DEPTH(OUT_DEPTH)) u_out_q (
    .clk(CLK), .rst(RST), .enq(do_exit), .enq_data(out_data), .deq(heard__ENA),
    .first(out_first), .full(out_full), .empty(out_empty)
  );

`ifdef LPM_STATS_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stat_req    <= '0;
      stat_recirc <= '0;
      stat_forced <= '0;
    end else begin
      if (say_fire)                stat_req    <= stat_req + 32'd1;
      if (do_recirc)               stat_recirc <= stat_recirc + 32'd1;
      if (do_exit & ~mem_resp_hit) stat_forced <= stat_forced + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lpm_recirc_engine.sv
// Self-checking bench for lpm_recirc_engine: directed scenarios plus randomized traffic
// scored against a trie-walk reference model and an in-order memory model.
module tb_lpm_recirc_engine;

  localparam int MAX_PASSES = 5;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        say__ENA = 1'b0;
  logic [31:0] say_meth = '0;
  logic [31:0] say_v = '0;
  logic        say__RDY;
  logic        heard__ENA;
  logic [31:0] heard_meth;
  logic [31:0] heard_v;
  logic        heard__RDY = 1'b1;
  logic        mem_req__ENA;
  logic [15:0] mem_req_addr;
  logic        mem_req__RDY = 1'b1;
  logic        mem_resp__ENA = 1'b1;
  logic [15:0] mem_resp_next = 16'hBEEF;
  logic        mem_resp_hit = 1'b1;
  logic        mem_resp__RDY;
`ifdef LPM_STATS_EN
  logic [31:0] stat_req, stat_recirc, stat_forced;
`endif

  always #5 CLK = ~CLK;

  lpm_recirc_engine dut (
    .CLK(CLK), .RST(RST),
    .say__ENA(say__ENA), .say_meth(say_meth), .say_v(say_v), .say__RDY(say__RDY),
    .heard__ENA(heard__ENA), .heard_meth(heard_meth), .heard_v(heard_v), .heard__RDY(heard__RDY),
    .mem_req__ENA(mem_req__ENA), .mem_req_addr(mem_req_addr), .mem_req__RDY(mem_req__RDY),
    .mem_resp__ENA(mem_resp__ENA), .mem_resp_next(mem_resp_next), .mem_resp_hit(mem_resp_hit),
    .mem_resp__RDY(mem_resp__RDY)
`ifdef LPM_STATS_EN
    , .stat_req(stat_req), .stat_recirc(stat_recirc), .stat_forced(stat_forced)
`endif
  );

  typedef struct { logic [31:0] meth; logic [31:0] key; } req_s;
  typedef struct { logic [15:0] addr; int rdy; } pend_s;

  int total_cnt = 0;
  int pass_cnt = 0;
  int cycle = 0;
  int mem_req_cnt = 0;
  int heard_cnt = 0;
  int say_pct, heard_pct, req_pct, resp_pct, lat_max;
  bit stale_resp = 1'b0;
  logic [31:0] last_heard_v = '0;

  req_s        say_q[$];
  pend_s       mem_q[$];
  logic [31:0] heard_log[$];
  logic [31:0] exp_map [logic [31:0]];
  logic [15:0] ov_next [logic [15:0]];
  bit          ov_hit  [logic [15:0]];

  // Trie contents: explicit overrides for directed scenarios, otherwise a fixed hash.
  function automatic void mem_read(input logic [15:0] a, output logic [15:0] nxt, output bit hit);
    if (ov_next.exists(a)) begin
      nxt = ov_next[a];
      hit = ov_hit[a];
    end else begin
      nxt = a * 16'd40503 + 16'd12345;
      hit = ((nxt % 3) == 0);
    end
  endfunction

  // Result of one lookup: walk the trie until a hit or the pass limit.
  function automatic logic [31:0] ref_lookup(input logic [31:0] key);
    logic [15:0] addr, nxt;
    bit hit;
    addr = key[15:0];
    for (int p = 1; p <= MAX_PASSES; p++) begin
      mem_read(addr, nxt, hit);
      if (hit || p == MAX_PASSES) return {16'h0, nxt};
      addr = nxt;
    end
    return '0;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total_cnt++;
    assert (observed === expected) pass_cnt++;
    else $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  task automatic setKnobs(input int s, input int h, input int rq, input int rs, input int lat);
    say_pct = s; heard_pct = h; req_pct = rq; resp_pct = rs; lat_max = lat;
  endtask

  task automatic addLink(input logic [15:0] a, input logic [15:0] nxt, input bit hit);
    ov_next[a] = nxt;
    ov_hit[a]  = hit;
  endtask

  // One cycle: drive inputs after the falling edge, then observe what the next rising edge commits.
  task automatic applyStimulus();
    logic [15:0] nxt;
    bit hit;
    @(negedge CLK);
    cycle++;
    say__ENA = 1'b0;
    if (say_q.size() > 0 && say__RDY && $urandom_range(99) < say_pct) begin
      say__ENA = 1'b1;
      say_meth = say_q[0].meth;
      say_v    = say_q[0].key;
    end
    heard__RDY    = ($urandom_range(99) < heard_pct);
    mem_req__RDY  = ($urandom_range(99) < req_pct);
    mem_resp__ENA = 1'b0;
    if (stale_resp) begin
      mem_resp__ENA = 1'b1;
      mem_resp_next = 16'hDEAD;
      mem_resp_hit  = 1'b1;
    end else if (mem_q.size() > 0 && mem_q[0].rdy <= cycle && $urandom_range(99) < resp_pct) begin
      mem_read(mem_q[0].addr, nxt, hit);
      mem_resp__ENA = 1'b1;
      mem_resp_next = nxt;
      mem_resp_hit  = hit;
    end
    #1;
    if (say__ENA) begin
      exp_map[say_meth] = ref_lookup(say_v);
      void'(say_q.pop_front());
    end
    if (mem_req__ENA) begin
      mem_req_cnt++;
      mem_q.push_back('{addr: mem_req_addr, rdy: cycle + $urandom_range(lat_max, 1)});
    end
    if (mem_resp__ENA && mem_resp__RDY && mem_q.size() > 0) void'(mem_q.pop_front());
    if (heard__ENA) begin
      heard_cnt++;
      heard_log.push_back(heard_meth);
      last_heard_v = heard_v;
      checkOutput("heard_known_meth", exp_map.exists(heard_meth), 1);
      if (exp_map.exists(heard_meth)) begin
        checkOutput("heard_v", heard_v, exp_map[heard_meth]);
        exp_map.delete(heard_meth);
      end
    end
  endtask

  task automatic runUntilIdle(input string tag, input int budget);
    int n = 0;
    while ((say_q.size() > 0 || exp_map.size() > 0) && n < budget) begin
      applyStimulus();
      n++;
    end
    checkOutput({tag, "_drained"}, (say_q.size() == 0 && exp_map.size() == 0), 1);
  endtask

  initial begin
    int base, n;
    setKnobs(100, 100, 100, 100, 1);

    // Reset state with ready/valid inputs pushed high
    #1;
    checkOutput("rst_say_rdy", say__RDY, 0);
    checkOutput("rst_heard_ena", heard__ENA, 0);
    checkOutput("rst_mem_req_ena", mem_req__ENA, 0);
    checkOutput("rst_mem_resp_rdy", mem_resp__RDY, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    applyStimulus();
    checkOutput("post_rst_say_rdy", say__RDY, 1);

    // Single lookup that hits on the first read
    addLink(16'h0010, 16'h0022, 1'b1);
    base = mem_req_cnt;
    say_q.push_back('{meth: 32'd7, key: 32'h10});
    runUntilIdle("t1", 50);
    checkOutput("t1_mem_reqs", mem_req_cnt - base, 1);
    checkOutput("t1_heard_meth", (heard_log.size() > 0) ? heard_log[$] : 32'hFFFF_FFFF, 7);
    checkOutput("t1_heard_v", last_heard_v, 32'h22);

    // Never hits: forced exit after MAX_PASSES reads
    for (int a = 16'h100; a < 16'h105; a++) addLink(16'(a), 16'(a + 1), 1'b0);
    base = mem_req_cnt;
    say_q.push_back('{meth: 32'd8, key: 32'h100});
    runUntilIdle("t2", 100);
    checkOutput("t2_mem_reqs", mem_req_cnt - base, MAX_PASSES);
    checkOutput("t2_heard_v", last_heard_v, 32'h105);
`ifdef LPM_STATS_EN
    checkOutput("t2_stat_forced", stat_forced, 1);
    checkOutput("t2_stat_recirc", stat_recirc, 4);
    checkOutput("t2_stat_req", stat_req, 2);
`endif

    // Four back-to-back lookups hitting at passes 3,1,2,1
    addLink(16'h200, 16'h201, 1'b0); addLink(16'h201, 16'h202, 1'b0); addLink(16'h202, 16'h2F3, 1'b1);
    addLink(16'h300, 16'h3AA, 1'b1);
    addLink(16'h400, 16'h401, 1'b0); addLink(16'h401, 16'h4BB, 1'b1);
    addLink(16'h500, 16'h5CC, 1'b1);
    heard_log.delete();
    base = mem_req_cnt;
    for (int i = 0; i < 4; i++) say_q.push_back('{meth: 32'(10 + i), key: 32'(16'h200 + 16'h100 * i)});
    runUntilIdle("t3", 200);
    checkOutput("t3_heard_count", heard_log.size(), 4);
    checkOutput("t3_mem_reqs", mem_req_cnt - base, 7);
    for (int m = 10; m < 14; m++) begin
      n = 0;
      foreach (heard_log[k]) if (heard_log[k] == 32'(m)) n++;
      checkOutput("t3_heard_once", n, 1);
    end

    // Output back-pressure: full outQ must stall a pending hit
    addLink(16'h800, 16'h888, 1'b1); addLink(16'h810, 16'h899, 1'b1); addLink(16'h820, 16'h8AA, 1'b1);
    setKnobs(100, 0, 100, 100, 1);
    heard_log.delete();
    for (int i = 0; i < 3; i++) say_q.push_back('{meth: 32'(60 + i), key: 32'(16'h800 + 16'h10 * i)});
    repeat (12) applyStimulus();
    checkOutput("t4_resp_held", mem_resp__RDY, 0);
    checkOutput("t4_pending_left", mem_q.size(), 1);
    setKnobs(100, 100, 100, 100, 1);
    runUntilIdle("t4", 50);
    for (int i = 0; i < 3; i++)
      checkOutput("t4_order", (heard_log.size() > i) ? heard_log[i] : 32'hFFFF_FFFF, 60 + i);

    // Recirculation wins the memory port over a waiting new request
    addLink(16'h600, 16'h601, 1'b0); addLink(16'h601, 16'h6CC, 1'b1); addLink(16'h700, 16'h7DD, 1'b1);
    setKnobs(100, 100, 100, 0, 1);
    base = mem_req_cnt;
    say_q.push_back('{meth: 32'd50, key: 32'h600});
    n = 0;
    while (mem_req_cnt == base && n < 10) begin applyStimulus(); n++; end
    checkOutput("t5_a_issued", mem_req_cnt - base, 1);
    req_pct = 0;
    say_q.push_back('{meth: 32'd51, key: 32'h700});
    repeat (3) applyStimulus();
    req_pct = 100; resp_pct = 100;
    applyStimulus();
    checkOutput("t5_recirc_ena", mem_req__ENA, 1);
    checkOutput("t5_recirc_addr", mem_req_addr, 16'h601);
    resp_pct = 0;
    applyStimulus();
    checkOutput("t5_enter_ena", mem_req__ENA, 1);
    checkOutput("t5_enter_addr", mem_req_addr, 16'h700);
    resp_pct = 100;
    runUntilIdle("t5", 50);

    // Reset with three lookups outstanding
    setKnobs(100, 100, 100, 0, 1);
    for (int i = 0; i < 3; i++) say_q.push_back('{meth: 32'(70 + i), key: 32'(16'h900 + 16'h10 * i)});
    repeat (8) applyStimulus();
    checkOutput("t6_inflight", mem_q.size(), 3);
    @(negedge CLK);
    say__ENA = 1'b0; heard__RDY = 1'b1; mem_req__RDY = 1'b1; mem_resp__ENA = 1'b1;
    RST = 1'b1;
    #1;
    checkOutput("t6_say_rdy", say__RDY, 0);
    checkOutput("t6_heard_ena", heard__ENA, 0);
    checkOutput("t6_mem_req_ena", mem_req__ENA, 0);
    checkOutput("t6_mem_resp_rdy", mem_resp__RDY, 0);
    say_q.delete(); mem_q.delete(); exp_map.delete();
    stale_resp = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    base = heard_cnt;
    repeat (6) applyStimulus();
    checkOutput("t6_stale_ignored", mem_resp__RDY, 0);
    checkOutput("t6_say_rdy_after", say__RDY, 1);
    checkOutput("t6_no_stale_heard", heard_cnt - base, 0);
    stale_resp = 1'b0;

    // Randomized traffic with back-pressure on every interface
    setKnobs(80, 70, 75, 80, 3);
    for (int i = 0; i < 40; i++) say_q.push_back('{meth: 32'(1000 + i), key: $urandom});
    runUntilIdle("rand", 4000);
    checkOutput("rand_mem_idle", mem_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
